// File: rtl/mux_select_arbiter.sv
// Two-source arbitrated mux: grants X or Y with a bounded hold time, then
// registers the selected source's data one cycle after the grant.
module mux_select_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] y_data,
    output logic [1:0]        grant,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic LP_X = 1'b0;
    localparam logic LP_Y = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_X = 2'd1,
        OWN_Y = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               lp;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                case (req)
                    2'b01:   next_state = OWN_X;
                    2'b10:   next_state = OWN_Y;
                    2'b11:   next_state = (lp == LP_Y) ? OWN_X : OWN_Y;
                    default: next_state = IDLE;
                endcase
            end
            OWN_X: begin
                if (!req[0])
                    next_state = req[1] ? OWN_Y : IDLE;
                else if (req[1] && hold_cnt == HOLD_LAST)
                    next_state = OWN_Y;
            end
            OWN_Y: begin
                if (!req[1])
                    next_state = req[0] ? OWN_X : IDLE;
                else if (req[0] && hold_cnt == HOLD_LAST)
                    next_state = OWN_X;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            lp        <= LP_Y;
        end else begin
            state     <= next_state;
            out_valid <= (grant != 2'b00);

            // Data follows the current owner, so it trails grant by one cycle.
            case (state)
                OWN_X:   out_data <= x_data;
                OWN_Y:   out_data <= y_data;
                default: out_data <= out_data;
            endcase

            if (next_state != state)
                hold_cnt <= '0;
            else if (state != IDLE && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + 1'b1;

            case (next_state)
                OWN_X: begin
                    grant <= 2'b01;
                    sel   <= 1'b0;
                    lp    <= LP_X;
                end
                OWN_Y: begin
                    grant <= 2'b10;
                    sel   <= 1'b1;
                    lp    <= LP_Y;
                end
                default: grant <= 2'b00;
            endcase
        end
    end

endmodule
